// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLB management-op sequencer with search-port arbitration
//
// Purpose: accepts one TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB op at a time, drives
// the matching TLB port for one cycle and returns a result via res_valid/res_ready.
// Search port 1 is shared with the load/store path; management searches win.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   op_valid/op_ready/op_*          op request (code, invtlb op, asid, vppn, index, entry)
//   res_valid/res_ready/res_*       result (code, found, index, entry)
//   mem_req/mem_*/mem_grant         load/store request for search port 1
//   tlb_s1_*                        TLB search port 1
//   tlb_r_index/tlb_r_entry         TLB read port
//   tlb_we/tlb_w_index/tlb_w_entry  TLB write port
//   tlb_invtlb_valid/tlb_invtlb_op  TLB invtlb port
//
// Build option: TLB_FILL_RANDOM_EN selects an LFSR-driven FILL index instead of
// the round-robin fill pointer.

module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [4:0]    op_inv_op,
    input  logic [9:0]    op_asid,
    input  logic [18:0]   op_vppn,
    input  logic [IW-1:0] op_index,
    input  logic [88:0]   op_entry,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [2:0]    res_code,
    output logic          res_found,
    output logic [IW-1:0] res_index,
    output logic [88:0]   res_entry,
    input  logic          mem_req,
    input  logic [18:0]   mem_vppn,
    input  logic          mem_va_bit12,
    input  logic [9:0]    mem_asid,
    output logic          mem_grant,
    output logic [18:0]   tlb_s1_vppn,
    output logic          tlb_s1_va_bit12,
    output logic [9:0]    tlb_s1_asid,
    input  logic          tlb_s1_found,
    input  logic [IW-1:0] tlb_s1_index,
    output logic [IW-1:0] tlb_r_index,
    input  logic [88:0]   tlb_r_entry,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [88:0]   tlb_w_entry,
    output logic          tlb_invtlb_valid,
    output logic [4:0]    tlb_invtlb_op
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SRCH = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_INV  = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [4:0]    inv_op_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic [IW-1:0] index_q;
    logic [88:0]   entry_q;
    logic [2:0]    res_code_q;
    logic          res_found_q;
    logic [IW-1:0] res_index_q;
    logic [88:0]   res_entry_q;
    logic [IW-1:0] fill_idx;
    logic          mgmt_search;

`ifdef TLB_FILL_RANDOM_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so FILL victims are spread out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign fill_idx = lfsr_q[IW-1:0];
`else
    logic [IW-1:0] fill_ptr_q;

    // Round-robin victim pointer; natural IW-bit overflow wraps TLBNUM-1 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_ptr_q <= '0;
        end else if (state_q == S_FILL) begin
            fill_ptr_q <= fill_ptr_q + IW'(1);
        end
    end

    assign fill_idx = fill_ptr_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        3'd0:    state_d = S_SRCH;
                        3'd1:    state_d = S_RD;
                        3'd2:    state_d = S_WR;
                        3'd3:    state_d = S_FILL;
                        3'd4:    state_d = S_INV;
                        default: state_d = S_RESP;
                    endcase
                end
            end
            S_RESP:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_RESP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            inv_op_q    <= '0;
            asid_q      <= '0;
            vppn_q      <= '0;
            index_q     <= '0;
            entry_q     <= '0;
            res_code_q  <= '0;
            res_found_q <= 1'b0;
            res_index_q <= '0;
            res_entry_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        inv_op_q    <= op_inv_op;
                        asid_q      <= op_asid;
                        vppn_q      <= op_vppn;
                        index_q     <= op_index;
                        entry_q     <= op_entry;
                        // Clear the result so reserved/INV ops report zeros.
                        res_code_q  <= op_code;
                        res_found_q <= 1'b0;
                        res_index_q <= '0;
                        res_entry_q <= '0;
                    end
                end
                S_SRCH: begin
                    res_found_q <= tlb_s1_found;
                    res_index_q <= tlb_s1_index;
                end
                S_RD: begin
                    res_index_q <= index_q;
                    // Invalid entries (e=0) are reported as all-zero.
                    res_entry_q <= tlb_r_entry[88] ? tlb_r_entry : '0;
                end
                S_WR:    res_index_q <= index_q;
                S_FILL:  res_index_q <= fill_idx;
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    assign mgmt_search      = (state_q == S_SRCH) || (state_q == S_INV);
    assign op_ready         = (state_q == S_IDLE);
    assign res_valid        = (state_q == S_RESP);
    assign res_code         = res_code_q;
    assign res_found        = res_found_q;
    assign res_index        = res_index_q;
    assign res_entry        = res_entry_q;

    assign mem_grant        = mem_req && !mgmt_search;
    assign tlb_s1_vppn      = mgmt_search ? vppn_q : (mem_grant ? mem_vppn : '0);
    assign tlb_s1_asid      = mgmt_search ? asid_q : (mem_grant ? mem_asid : '0);
    assign tlb_s1_va_bit12  = mem_grant ? mem_va_bit12 : 1'b0;

    assign tlb_r_index      = index_q;
    assign tlb_we           = (state_q == S_WR) || (state_q == S_FILL);
    assign tlb_w_index      = (state_q == S_FILL) ? fill_idx : index_q;
    assign tlb_w_entry      = entry_q;
    assign tlb_invtlb_valid = (state_q == S_INV);
    assign tlb_invtlb_op    = inv_op_q;

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences TLB-management instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) onto the shared TLB's search port 1, read port, write port and invtlb port.
- Sits between the CSR/writeback stage and the TLB.
- Arbitrates search port 1 between the load/store path and management ops.
- Returns one result per op through a valid/ready handshake.

Parameters:
- TLBNUM, 16, TLB entry count (power of 2); IW=$clog2(TLBNUM) is the index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- op_valid  in  1  management op request
- op_ready  out  1  controller can accept an op
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 reserved
- op_inv_op  in  5  invtlb opcode
- op_asid  in  10  ASID for SRCH/INV
- op_vppn  in  19  VPPN for SRCH/INV
- op_index  in  IW  entry index for RD/WR
- op_entry  in  89  write entry, packed {e,vppn,ps,asid,g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1}
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_code  out  3  op_code of the completed op
- res_found  out  1  SRCH hit
- res_index  out  IW  SRCH hit index / RD index / WR/FILL written index
- res_entry  out  89  RD entry, same packing as op_entry
- mem_req  in  1  load/store wants search port 1
- mem_vppn  in  19  load/store VPPN
- mem_va_bit12  in  1  load/store VA bit 12
- mem_asid  in  10  load/store ASID
- mem_grant  out  1  search port 1 driven by load/store this cycle
- tlb_s1_vppn  out  19  to TLB s1_vppn
- tlb_s1_va_bit12  out  1  to TLB s1_va_bit12
- tlb_s1_asid  out  10  to TLB s1_asid
- tlb_s1_found  in  1  from TLB s1_found
- tlb_s1_index  in  IW  from TLB s1_index
- tlb_r_index  out  IW  to TLB r_index
- tlb_r_entry  in  89  TLB read-port fields, packed
- tlb_we  out  1  TLB write enable
- tlb_w_index  out  IW  TLB write index
- tlb_w_entry  out  89  TLB write fields, packed
- tlb_invtlb_valid  out  1  TLB invtlb pulse
- tlb_invtlb_op  out  5  TLB invtlb opcode

Behaviour:
- FSM states: IDLE, SRCH, RD, WR, FILL, INV, RESP. Reset state is IDLE.
- Reset values: op_ready=1; res_valid=0; res_*=0; tlb_we=0; tlb_invtlb_valid=0; fill pointer=0.
- IDLE:
  - op_ready=1.
  - On op_valid, capture all op_* fields and go to the state selected by op_code.
  - Reserved codes go directly to RESP with res_found=0 and res_entry=0, and touch no TLB port.
- All non-IDLE states hold op_ready=0.
- SRCH (1 cycle):
  - tlb_s1_vppn/asid = captured op fields; va_bit12=0.
  - Latch found/index.
  - Go to RESP.
- RD (1 cycle):
  - tlb_r_index=op_index.
  - Latch tlb_r_entry; if its e bit=0, res_entry=0.
  - Go to RESP.
- WR (1 cycle): tlb_we=1, w_index=op_index, w_entry=op_entry. Go to RESP.
- FILL (1 cycle):
  - tlb_we=1, w_index=fill pointer, w_entry=op_entry.
  - res_index=fill pointer.
  - Fill pointer advances; TLBNUM-1 wraps to 0.
- INV (1 cycle):
  - tlb_invtlb_valid=1, tlb_invtlb_op=op_inv_op.
  - Search port 1 carries op_asid/op_vppn in the same cycle.
  - Any 5-bit value passes through unchecked.
- tlb_we and tlb_invtlb_valid are never high together; each is a single-cycle pulse per op.
- RESP:
  - res_valid=1; res_* are stable until res_ready.
  - On res_ready, go to IDLE.
  - The next op is accepted no earlier than the cycle after the handshake.
- Latency: accept at cycle N, TLB access at N+1, res_valid at N+2.
- Port-1 arbitration:
  - mem_grant = mem_req and state not in {SRCH, INV}.
  - When granted, tlb_s1_* = mem_*.
  - When not granted and not in SRCH/INV, tlb_s1_* = 0.
  - A management search therefore stalls load/store for exactly one cycle.
- Reset asserted mid-operation:
  - Immediately drops tlb_we, tlb_invtlb_valid and res_valid.
  - Discards the op; no partial write occurs on the reset edge.

Optional Feature:
- Macro: TLB_FILL_RANDOM_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4) with reset seed 8'h5A advances every cycle. The FILL index is lfsr[IW-1:0]; res_index reports it.
- Undefined: the round-robin fill pointer described above is used.

Test Plan:
- Reset, then WR index 3 with vppn=19'h12345, asid=10'h001, e=1 -> tlb_we high for exactly one cycle at N+1 with w_index=3; res_valid at N+2 with res_code=2, res_index=3.
- SRCH vppn=19'h12345, asid=10'h001 after that write -> res_found=1, res_index=3. SRCH asid=10'h002 with g=0 -> res_found=0.
- RD index 3 -> res_entry equals the written entry. RD of an index with e=0 -> res_entry=0.
- Round-robin build: FILL x17 with res_ready held high -> res_index sequence 0,1,…,15,0.
- mem_req held high during SRCH -> mem_grant=0 for exactly the SRCH cycle, 1 otherwise. INV op=4, asid=10'h001 -> tlb_invtlb_valid one-cycle pulse with tlb_s1_asid=10'h001.
- Reset asserted during the WR state -> tlb_we drops asynchronously, state returns to IDLE, op_ready=1, res_valid=0. res_ready held low in RESP -> res_valid and res_* stay stable and op_valid is ignored.
